// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter_if
// Description : Request/response bundle between one data-memory requester and
//               the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic          we;
    logic [1:0]    size;
    logic          is_unsigned;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          rsp_valid;
    logic [DW-1:0] rdata;
    logic          err;

    modport master (
        output req_valid, we, size, is_unsigned, addr, wdata,
        input  req_ready, rsp_valid, rdata, err
    );

    modport slave (
        input  req_valid, we, size, is_unsigned, addr, wdata,
        output req_ready, rsp_valid, rdata, err
    );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Round-robin arbiter sharing a single-port data memory between
//               the LSU (p0) and debug/DMA (p1), with lane steering and
//               load sign/zero extension.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  wire logic          clk,
    input  wire logic          rst,
    dmem_arbiter_if.slave      p0,
    dmem_arbiter_if.slave      p1,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_din,
    output logic [3:0]         mem_we,
    input  wire logic [DW-1:0] mem_dout
);
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_MEM  = 2'd1;
    localparam logic [1:0] c_RSP  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          last_grant_q;
    logic          port_q;
    logic          we_q;
    logic          uns_q;
    logic          err_q;
    logic [1:0]    size_q;
    logic [1:0]    off_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_din_q;
    logic [3:0]    mem_we_q;

    logic          w_both;
    logic          w_any;
    logic          w_gnt_port;
    logic          w_grant;
    logic          w_sel_we;
    logic [1:0]    w_sel_size;
    logic          w_sel_uns;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;
    logic          w_misalign;
    logic [3:0]    w_be;
    logic [DW-1:0] w_din;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [DW-1:0] w_load;
    logic [DW-1:0] w_rdata;
    logic          w_rsp;

    // Contention goes to the port that was not served last.
    assign w_both     = p0.req_valid & p1.req_valid;
    assign w_any      = p0.req_valid | p1.req_valid;
    assign w_gnt_port = w_both ? ~last_grant_q : p1.req_valid;
    assign w_grant    = (state_q == c_IDLE) & w_any & ~rst;

    assign p0.req_ready = w_grant & ~w_gnt_port;
    assign p1.req_ready = w_grant &  w_gnt_port;

    assign w_sel_we    = w_gnt_port ? p1.we          : p0.we;
    assign w_sel_size  = w_gnt_port ? p1.size        : p0.size;
    assign w_sel_uns   = w_gnt_port ? p1.is_unsigned : p0.is_unsigned;
    assign w_sel_addr  = w_gnt_port ? p1.addr        : p0.addr;
    assign w_sel_wdata = w_gnt_port ? p1.wdata       : p0.wdata;

    always_comb begin
        w_misalign = 1'b0;
        case (w_sel_size)
            2'b00:   w_misalign = 1'b0;
            2'b01:   w_misalign = w_sel_addr[0];
            2'b10:   w_misalign = (w_sel_addr[1:0] != 2'b00);
            default: w_misalign = 1'b1;
        endcase
    end

    always_comb begin
        w_be  = 4'b0000;
        w_din = w_sel_wdata;
        case (w_sel_size)
            2'b00: begin
                w_be  = 4'b0001 << w_sel_addr[1:0];
                w_din = {4{w_sel_wdata[7:0]}};
            end
            2'b01: begin
                w_be  = 4'b0011 << w_sel_addr[1:0];
                w_din = {2{w_sel_wdata[15:0]}};
            end
            2'b10: begin
                w_be  = 4'b1111;
                w_din = w_sel_wdata;
            end
            default: w_be = 4'b0000;
        endcase
        if (!w_sel_we || w_misalign) begin
            w_be = 4'b0000;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:  state_d = w_grant ? c_MEM : c_IDLE;
            c_MEM:   state_d = c_RSP;
            c_RSP:   state_d = c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    // Memory-side outputs are registered on the grant edge so they are
    // presented throughout MEM; byte enables self-clear after one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= c_IDLE;
            last_grant_q <= 1'b1;
            port_q       <= 1'b0;
            we_q         <= 1'b0;
            uns_q        <= 1'b0;
            err_q        <= 1'b0;
            size_q       <= 2'b00;
            off_q        <= 2'b00;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            mem_we_q     <= 4'b0000;
        end else begin
            state_q  <= state_d;
            mem_we_q <= 4'b0000;
            if (w_grant) begin
                last_grant_q <= w_gnt_port;
                port_q       <= w_gnt_port;
                we_q         <= w_sel_we;
                uns_q        <= w_sel_uns;
                err_q        <= w_misalign;
                size_q       <= w_sel_size;
                off_q        <= w_sel_addr[1:0];
                mem_addr_q   <= w_sel_addr;
                mem_din_q    <= w_din;
                mem_we_q     <= w_be;
            end
        end
    end

    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign mem_we   = mem_we_q;

    always_comb begin
        w_byte = mem_dout[7:0];
        case (off_q)
            2'd0:    w_byte = mem_dout[7:0];
            2'd1:    w_byte = mem_dout[15:8];
            2'd2:    w_byte = mem_dout[23:16];
            default: w_byte = mem_dout[31:24];
        endcase
    end

    assign w_half = off_q[1] ? mem_dout[31:16] : mem_dout[15:0];

    always_comb begin
        w_load = mem_dout;
        case (size_q)
            2'b00:   w_load = uns_q ? {{(DW-8){1'b0}}, w_byte}
                                    : {{(DW-8){w_byte[7]}}, w_byte};
            2'b01:   w_load = uns_q ? {{(DW-16){1'b0}}, w_half}
                                    : {{(DW-16){w_half[15]}}, w_half};
            default: w_load = mem_dout;
        endcase
    end

    assign w_rsp   = (state_q == c_RSP);
    assign w_rdata = (err_q | we_q) ? '0 : w_load;

    assign p0.rsp_valid = w_rsp & ~port_q;
    assign p0.err       = w_rsp & ~port_q & err_q;
    assign p0.rdata     = (w_rsp & ~port_q) ? w_rdata : '0;

    assign p1.rsp_valid = w_rsp & port_q;
    assign p1.err       = w_rsp & port_q & err_q;
    assign p1.rdata     = (w_rsp & port_q) ? w_rdata : '0;
endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Scoreboard bench for dmem_arbiter with a behavioural memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [3:0]  mem_we;
    logic [31:0] mem_dout = 32'h0;
    logic [31:0] mem [0:1023];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    typedef struct { logic [31:0] rd; logic err; int cyc; } rsp_t;
    typedef struct { logic [3:0] we; logic [31:0] din; logic [31:0] addr; } wr_t;
    rsp_t rq0[$];
    rsp_t rq1[$];
    wr_t  wq[$];
    int   grants[$];

    dmem_arbiter_if #(.AW(32), .DW(32)) p0_if ();
    dmem_arbiter_if #(.AW(32), .DW(32)) p1_if ();

    dmem_arbiter #(.AW(32), .DW(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .p0       (p0_if.slave),
        .p1       (p1_if.slave),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_we   (mem_we),
        .mem_dout (mem_dout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    end

    always @(posedge clk) begin
        mem_dout <= mem[mem_addr[11:2]];
        for (int b = 0; b < 4; b++)
            if (mem_we[b]) mem[mem_addr[11:2]][b*8 +: 8] <= mem_din[b*8 +: 8];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_rsp(input int port, input logic [31:0] rd, input logic err);
        rsp_t e;
        n_chk++;
        if ((port == 0 && rq0.size() == 0) || (port == 1 && rq1.size() == 0)) begin
            n_fail++;
            $display("FAIL rsp_p%0d unexpected: got rdata %h err %0d at cycle %0d, expected none", port, rd, err, cyc);
        end else begin
            e = (port == 0) ? rq0.pop_front() : rq1.pop_front();
            if (rd !== e.rd || err !== e.err || cyc != e.cyc) begin
                n_fail++;
                $display("FAIL rsp_p%0d: got rdata %h err %0d cycle %0d, expected rdata %h err %0d cycle %0d",
                         port, rd, err, cyc, e.rd, e.err, e.cyc);
            end
        end
    endtask

    // Monitor: responses and memory writes are checked against the scoreboard.
    always @(negedge clk) begin
        wr_t w;
        if (p0_if.rsp_valid) check_rsp(0, p0_if.rdata, p0_if.err);
        if (p1_if.rsp_valid) check_rsp(1, p1_if.rdata, p1_if.err);
        if (mem_we != 4'b0000) begin
            n_chk++;
            if (wq.size() == 0) begin
                n_fail++;
                $display("FAIL mem_write unexpected: got we %b din %h addr %h, expected none", mem_we, mem_din, mem_addr);
            end else begin
                w = wq.pop_front();
                if (mem_we !== w.we || mem_din !== w.din || mem_addr !== w.addr) begin
                    n_fail++;
                    $display("FAIL mem_write: got we %b din %h addr %h, expected we %b din %h addr %h",
                             mem_we, mem_din, mem_addr, w.we, w.din, w.addr);
                end
            end
        end
    end

    task automatic drive(input int port, input logic v, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        if (port == 0) begin
            p0_if.req_valid = v; p0_if.we = we; p0_if.size = sz;
            p0_if.is_unsigned = uns; p0_if.addr = addr; p0_if.wdata = wdata;
        end else begin
            p1_if.req_valid = v; p1_if.we = we; p1_if.size = sz;
            p1_if.is_unsigned = uns; p1_if.addr = addr; p1_if.wdata = wdata;
        end
    endtask

    task automatic issue(input int port, input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rd, input logic exp_err,
                         input logic [3:0] exp_we, input logic [31:0] exp_din,
                         input bit expect_rsp);
        bit   got = 0;
        int   n = 0;
        logic rdy;
        rsp_t r;
        wr_t  w;
        drive(port, 1'b1, we, sz, uns, addr, wdata);
        while (!got && n < 50) begin
            @(negedge clk);
            rdy = (port == 0) ? p0_if.req_ready : p1_if.req_ready;
            if (rdy) begin
                got = 1;
                grants.push_back(port);
                if (expect_rsp) begin
                    r.rd = exp_rd; r.err = exp_err; r.cyc = cyc + 2;
                    if (port == 0) rq0.push_back(r); else rq1.push_back(r);
                end
                if (exp_we != 4'b0000) begin
                    w.we = exp_we; w.din = exp_din; w.addr = addr;
                    wq.push_back(w);
                end
            end
            n++;
        end
        if (!got) begin
            n_chk++; n_fail++;
            $display("FAIL grant_timeout_p%0d: got no ready in 50 cycles, expected ready", port);
        end
        @(posedge clk);
        #1;
        drive(port, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        drive(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
        repeat (2) @(negedge clk);
        chk("rst_p0_ready", {31'b0, p0_if.req_ready}, 32'h0);
        chk("rst_p1_ready", {31'b0, p1_if.req_ready}, 32'h0);
        chk("rst_rsp_valid", {30'b0, p1_if.rsp_valid, p0_if.rsp_valid}, 32'h0);
        chk("rst_err", {30'b0, p1_if.err, p0_if.err}, 32'h0);
        chk("rst_rdata", p0_if.rdata | p1_if.rdata, 32'h0);
        chk("rst_mem_we", {28'b0, mem_we}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_din", mem_din, 32'h0);
        drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1 rst = 1'b0;

        // word store/load
        issue(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0, 4'b1111, 32'hDEADBEEF, 1);
        issue(0, 0, 2'b10, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 4'b0000, 32'h0,        1);
        // byte store, signed and unsigned loads
        issue(1, 1, 2'b00, 0, 32'h13, 32'h80,       32'h0,        0, 4'b1000, 32'h80808080, 1);
        issue(1, 0, 2'b00, 0, 32'h13, 32'h0,        32'hFFFFFF80, 0, 4'b0000, 32'h0,        1);
        issue(1, 0, 2'b00, 1, 32'h13, 32'h0,        32'h00000080, 0, 4'b0000, 32'h0,        1);
        issue(0, 0, 2'b01, 0, 32'h12, 32'h0,        32'hFFFF80AD, 0, 4'b0000, 32'h0,        1);
        issue(0, 0, 2'b00, 1, 32'h11, 32'h0,        32'h000000BE, 0, 4'b0000, 32'h0,        1);
        // half store/load
        issue(0, 1, 2'b01, 0, 32'h22, 32'h1234,     32'h0,        0, 4'b1100, 32'h12341234, 1);
        issue(0, 0, 2'b01, 1, 32'h22, 32'h0,        32'h00001234, 0, 4'b0000, 32'h0,        1);
        issue(0, 0, 2'b10, 0, 32'h20, 32'h0,        32'h12340000, 0, 4'b0000, 32'h0,        1);
        // misaligned and illegal accesses
        issue(0, 0, 2'b01, 0, 32'h21, 32'h0,        32'h0,        1, 4'b0000, 32'h0,        1);
        issue(1, 1, 2'b10, 0, 32'h06, 32'hCAFEF00D, 32'h0,        1, 4'b0000, 32'h0,        1);
        issue(1, 0, 2'b11, 0, 32'h10, 32'h0,        32'h0,        1, 4'b0000, 32'h0,        1);
        issue(0, 0, 2'b10, 0, 32'h04, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        1);

        // contention after a fresh reset: p0 must win first
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        grants.delete();
        fork
            begin
                issue(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'h80ADBEEF, 0, 4'b0000, 32'h0, 1);
                issue(0, 0, 2'b10, 0, 32'h20, 32'h0, 32'h12340000, 0, 4'b0000, 32'h0, 1);
            end
            begin
                issue(1, 0, 2'b00, 1, 32'h13, 32'h0, 32'h00000080, 0, 4'b0000, 32'h0, 1);
                issue(1, 0, 2'b01, 0, 32'h22, 32'h0, 32'h00001234, 0, 4'b0000, 32'h0, 1);
            end
        join
        chk("grant_count", grants.size(), 32'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("grant_order_%0d", i), (i < grants.size()) ? grants[i] : -1, i % 2);

        // reset during MEM of a store drops the write and the response
        repeat (3) @(posedge clk);
        #1;
        issue(0, 1, 2'b10, 0, 32'h40, 32'h11111111, 32'h0, 0, 4'b1111, 32'h11111111, 0);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_mem_we", {28'b0, mem_we}, 32'h0);
        @(negedge clk);
        chk("rst_mid_rsp", {30'b0, p1_if.rsp_valid, p0_if.rsp_valid}, 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        issue(0, 0, 2'b10, 0, 32'h40, 32'h0, 32'h0, 0, 4'b0000, 32'h0, 1);
        issue(1, 1, 2'b10, 0, 32'h44, 32'h55AA33CC, 32'h0, 0, 4'b1111, 32'h55AA33CC, 1);
        issue(1, 0, 2'b10, 0, 32'h44, 32'h0, 32'h55AA33CC, 0, 4'b0000, 32'h0, 1);

        repeat (5) @(negedge clk);
        chk("rq0_drained", rq0.size(), 32'd0);
        chk("rq1_drained", rq1.size(), 32'd0);
        chk("wq_drained", wq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 is the core load/store unit, port 1 is the debug/DMA master.
- Arbitrates round-robin and generates byte write enables plus lane-replicated write data from the access size.
- Aligns and sign/zero-extends read data, and rejects misaligned accesses with an error response.
- Sits between the LSU/debug masters and the data memory. The memory has a 32-bit registered read, 4-bit byte write enables, and word index addr[11:2].

Parameters:
- AW, 32, address width of requester and memory address ports.
- DW, 32, data width. Fixed 32; byte-lane logic assumes 4 lanes.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- pN_req_valid  in  1  request from port N (N=0,1).
- pN_req_ready  out  1  port N request accepted this cycle.
- pN_we  in  1  1=store, 0=load.
- pN_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- pN_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- pN_addr  in  AW  byte address.
- pN_wdata  in  DW  store data, right-justified.
- pN_rsp_valid  out  1  one-cycle response pulse to port N.
- pN_rdata  out  DW  formatted load data; 0 for stores and errors.
- pN_err  out  1  misaligned or illegal access; qualified by rsp_valid.
- mem_addr  out  AW  byte address to the memory.
- mem_din  out  DW  lane-replicated write data.
- mem_we  out  4  byte write enables.
- mem_dout  in  DW  registered read data, valid the cycle after the address is presented.

Behaviour:
- Reset values: state=IDLE, all pN_rsp_valid=0, pN_err=0, pN_rdata=0, mem_we=0, mem_addr=0, mem_din=0, last_grant=1. pN_req_ready is forced 0 while rst is high.
- FSM states:
  - IDLE: arbitrate. On a grant, capture the granted request into registers and go to MEM.
  - MEM: always go to RSP.
  - RSP: always go to IDLE.
- pN_req_ready is asserted combinationally only in IDLE, only for the granted port.
- Arbitration in IDLE:
  - Only one port valid: that port is granted.
  - Both valid: the port other than last_grant wins; last_grant updates on each grant.
  - After reset, p0 wins the first contention.
- Timing for a request accepted in cycle T:
  - T+1 (MEM): mem_addr/mem_din driven from the captured registers. mem_we is nonzero only in this state.
  - T+2 (RSP): rsp_valid=1 for exactly one cycle on the granted port, with pN_rdata formatted combinationally from mem_dout.
  - Back in IDLE at T+3.
  - Throughput: one access per 3 cycles.
  - The non-granted port holds its request; its ready stays 0.
- Byte enables (off = addr[1:0]):
  - byte: 4'b0001<<off, din={4{wdata[7:0]}}.
  - half: 4'b0011<<off, din={2{wdata[15:0]}}.
  - word: 4'b1111, din=wdata.
  - Loads: mem_we=0.
- Alignment errors: half with addr[0]=1, word with addr[1:0]!=0, or size=11.
  - mem_we stays 0 and no memory write occurs.
  - Same T+2 timing: err=1, rdata=0.
- Load formatting:
  - Select the lane (byte lane off, half lane off[1]).
  - Extend to 32 bits per pN_unsigned. Word loads pass through unchanged.
- Store response: rsp_valid=1, err=0, rdata=0.
- mem_dout returns pre-write contents on the write cycle. The arbiter ignores it for stores.
- mem_addr/mem_din hold their last values outside MEM. They are don't-care to the memory because mem_we=0.
- Reset mid-operation: async return to IDLE with mem_we=0 immediately. Any pending response is dropped (no rsp_valid). last_grant=1.
- Simultaneous valid on both ports at the same edge as RSP→IDLE: arbitration occurs in the IDLE cycle, not in RSP.

Test Plan:
- p0 store word addr 0x10 data 0xDEADBEEF, then p0 load word 0x10 -> mem_we=1111 at T+1; load rsp at T+2 rdata=0xDEADBEEF, err=0.
- p1 store byte addr 0x13 data 0x80, then load byte signed and unsigned at 0x13 -> mem_we=1000, din=0x80808080; rdata 0xFFFFFF80 then 0x00000080.
- p0 store half addr 0x22 data 0x1234, load half unsigned 0x22 -> mem_we=1100, rdata=0x00001234; load word 0x20 -> upper half 0x1234.
- Half load at 0x21 and word store at 0x06 -> err=1, rdata=0, mem_we stays 0; a later word read at 0x04 shows unchanged contents.
- Both ports continuously valid for 4 requests -> grants alternate p0,p1,p0,p1 starting with p0; each rsp 2 cycles after its ready.
- Assert rst during the MEM state of a store -> mem_we drops to 0 asynchronously, no rsp_valid; the next request after reset completes normally.
